// File: rtl/imem_access_arbiter_pkg.sv
// Shared constants, FSM encoding and word-address legality check for the
// instruction-memory access arbiter.
package imem_pkg;

   localparam int DEPTH  = 16384;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   // A word access must be 4-byte aligned and leave room for all four bytes.
   function automatic logic addr_legal(input logic [31:0] addr, input int depth);
      return (addr[1:0] == 2'b00) && (addr <= 32'(depth - 4));
   endfunction

endpackage

// File: rtl/imem_starve_counter.sv
// Saturating count of cycles a pending load has been refused; at_limit
// tells the arbiter to give the load priority on the next word.
module imem_starve_counter #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares the byte-wide instruction memory between the IF-stage word fetch and
// the program loader, which writes big-endian words one byte per cycle.
module imem_access_arbiter #(
   parameter int  DEPTH        = imem_pkg::DEPTH,
   parameter int  STARVE_LIMIT = 8,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fetch_req,
   input  logic [31:0]   fetch_pc,
   output logic          fetch_gnt,
   output logic          fetch_stall,
   output logic          fetch_fault,
   input  logic          ld_valid,
   input  logic [31:0]   ld_addr,
   input  logic [31:0]   ld_data,
   output logic          ld_ready,
   output logic          ld_done,
   output logic          ld_err,
   output logic [31:0]   mem_rd_addr,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_wr_addr,
   output logic [7:0]    mem_wr_data,
   output logic          busy
);

   import imem_pkg::*;

   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   state_t        state;
   logic [1:0]    byte_cnt;
   logic [AW-1:0] addr_q;
   logic [31:0]   data_q;
   logic          ld_done_q;
   logic          ld_err_q;

   logic idle;
   logic fault;
   logic ld_legal;
   logic load_win;
   logic at_limit;
   logic wr_last;
   logic starve_inc;
   logic starve_clr;

   assign idle     = (state == IDLE);
   assign fault    = fetch_req & ~addr_legal(fetch_pc, DEPTH);
   assign ld_legal = addr_legal(ld_addr, DEPTH);
   assign load_win = idle & ld_valid & (~fetch_req | at_limit);
   assign wr_last  = ~idle & (byte_cnt == 2'd3);

   // Handshake outputs are forced low while reset is held so nothing is
   // granted or accepted before the block is running.
   assign ld_ready    = rst_n & load_win;
   assign fetch_fault = rst_n & fault;
   assign fetch_gnt   = rst_n & idle & fetch_req & ~load_win & ~fault;
   assign fetch_stall = rst_n & fetch_req & ~fault & ~fetch_gnt;

   assign mem_rd_addr = fetch_pc;
   assign mem_wr_en   = ~idle;
   assign mem_wr_addr = addr_q + AW'(byte_cnt);
   assign mem_wr_data = byte_sel(data_q, byte_cnt);
   assign busy        = ~idle;
   assign ld_done     = ld_done_q;
   assign ld_err      = ld_err_q;

   assign starve_inc = idle & ld_valid & ~load_win;
   assign starve_clr = ld_ready | ~ld_valid | wr_last;

   imem_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .at_limit (at_limit)
   );

   // FSM: an accepted legal word owns the write port for exactly four cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         byte_cnt  <= '0;
         ld_done_q <= 1'b0;
         ld_err_q  <= 1'b0;
      end else begin
         ld_done_q <= 1'b0;
         ld_err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (ld_ready) begin
                  if (ld_legal) begin
                     state    <= WRITE;
                     byte_cnt <= '0;
                  end else begin
                     ld_err_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               byte_cnt <= byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) begin
                  state     <= IDLE;
                  ld_done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Captured word; upper address bits are dropped since legality bounds them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         data_q <= '0;
      end else if (ld_ready && ld_legal) begin
         addr_q <= ld_addr[AW-1:0];
         data_q <= ld_data;
      end
   end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a byte-wide memory model that
// captures the write port mid-cycle.
module tb_imem_access_arbiter;

   localparam int DEPTH = 16384;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_gnt, fetch_stall, fetch_fault;
   logic        ld_valid;
   logic [31:0] ld_addr, ld_data;
   logic        ld_ready, ld_done, ld_err;
   logic [31:0] mem_rd_addr;
   logic        mem_wr_en;
   logic [13:0] mem_wr_addr;
   logic [7:0]  mem_wr_data;
   logic        busy;

   logic [7:0]  mem [DEPTH];
   int          wr_cnt   = 0;
   int          done_cnt = 0;
   int          total    = 0;
   int          passed   = 0;
   int          failed   = 0;

   imem_access_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req   (fetch_req),
      .fetch_pc    (fetch_pc),
      .fetch_gnt   (fetch_gnt),
      .fetch_stall (fetch_stall),
      .fetch_fault (fetch_fault),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .ld_done     (ld_done),
      .ld_err      (ld_err),
      .mem_rd_addr (mem_rd_addr),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_wr_en === 1'b1) begin
            mem[mem_wr_addr] = mem_wr_data;
            wr_cnt++;
         end
         if (ld_done === 1'b1) done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      logic [13:0] b;
      b = a[13:0];
      return {mem[b], mem[b + 14'd1], mem[b + 14'd2], mem[b + 14'd3]};
   endfunction

   task automatic write_cycles(input string tag, input int addr,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic exp_stall);
      logic [7:0] b [4];
      b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("%s_wren%0d", tag, i), mem_wr_en, 1);
         chk($sformatf("%s_waddr%0d", tag, i), mem_wr_addr, addr + i);
         chk($sformatf("%s_wdata%0d", tag, i), mem_wr_data, b[i]);
         chk($sformatf("%s_busy%0d", tag, i), busy, 1);
         chk($sformatf("%s_rdy%0d", tag, i), ld_ready, 0);
         chk($sformatf("%s_gnt%0d", tag, i), fetch_gnt, 0);
         chk($sformatf("%s_stall%0d", tag, i), fetch_stall, exp_stall);
         chk($sformatf("%s_done%0d", tag, i), ld_done, 0);
         next_cycle();
      end
   endtask

   task automatic illegal_load(input string tag, input logic [31:0] addr);
      fetch_req = 1'b0;
      ld_valid  = 1'b1;
      ld_addr   = addr;
      ld_data   = 32'hCAFEF00D;
      @(negedge clk);
      chk({tag, "_rdy"}, ld_ready, 1);
      next_cycle();
      ld_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_err"}, ld_err, 1);
      chk({tag, "_wren"}, mem_wr_en, 0);
      chk({tag, "_busy"}, busy, 0);
      next_cycle();
      @(negedge clk);
      chk({tag, "_err_clr"}, ld_err, 0);
      chk({tag, "_wren2"}, mem_wr_en, 0);
      next_cycle();
   endtask

   initial begin
      int w0, d0;
      rst_n     = 1'b0;
      fetch_req = 1'b1;
      fetch_pc  = 32'd102;
      ld_valid  = 1'b1;
      ld_addr   = 32'd0;
      ld_data   = 32'd0;
      #2;
      chk("rst_gnt", fetch_gnt, 0);
      chk("rst_stall", fetch_stall, 0);
      chk("rst_fault", fetch_fault, 0);
      chk("rst_rdy", ld_ready, 0);
      chk("rst_done", ld_done, 0);
      chk("rst_err", ld_err, 0);
      chk("rst_wren", mem_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdaddr", mem_rd_addr, 102);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      ld_valid = 1'b0;

      // fetch only
      for (int i = 0; i < 3; i++) begin
         fetch_pc = 32'd100 + 32'(4 * i);
         @(negedge clk);
         chk($sformatf("f_gnt%0d", i), fetch_gnt, 1);
         chk($sformatf("f_stall%0d", i), fetch_stall, 0);
         chk($sformatf("f_rdaddr%0d", i), mem_rd_addr, 100 + 4 * i);
         chk($sformatf("f_wren%0d", i), mem_wr_en, 0);
         next_cycle();
      end

      // single load in idle
      fetch_req = 1'b0;
      ld_valid  = 1'b1;
      ld_addr   = 32'd700;
      ld_data   = 32'h48080000;
      @(negedge clk);
      chk("l1_rdy", ld_ready, 1);
      chk("l1_busy0", busy, 0);
      next_cycle();
      ld_valid = 1'b0;
      write_cycles("l1", 700, 8'h48, 8'h08, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      chk("l1_done", ld_done, 1);
      chk("l1_busy_end", busy, 0);
      chk("l1_wren_end", mem_wr_en, 0);
      next_cycle();
      fetch_req = 1'b1;
      fetch_pc  = 32'd700;
      @(negedge clk);
      chk("l1_done_clr", ld_done, 0);
      chk("l1_fgnt", fetch_gnt, 1);
      chk("l1_fword", rd_word(mem_rd_addr), 32'h48080000);
      next_cycle();

      // load competing with continuous fetch
      fetch_pc = 32'd200;
      ld_valid = 1'b1;
      ld_addr  = 32'd900;
      ld_data  = 32'hA1B2C3D4;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("lf_deny_rdy%0d", i), ld_ready, 0);
         chk($sformatf("lf_deny_gnt%0d", i), fetch_gnt, 1);
         chk($sformatf("lf_deny_stall%0d", i), fetch_stall, 0);
         next_cycle();
      end
      @(negedge clk);
      chk("lf_acc_rdy", ld_ready, 1);
      chk("lf_acc_gnt", fetch_gnt, 0);
      chk("lf_acc_stall", fetch_stall, 1);
      next_cycle();
      ld_valid = 1'b0;
      write_cycles("lf", 900, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1);
      @(negedge clk);
      chk("lf_done", ld_done, 1);
      chk("lf_resume_gnt", fetch_gnt, 1);
      chk("lf_resume_stall", fetch_stall, 0);
      next_cycle();

      // illegal loads and fetch boundary
      illegal_load("il702", 32'd702);
      illegal_load("il16381", 32'd16381);
      fetch_req = 1'b1;
      fetch_pc  = 32'd16382;
      @(negedge clk);
      chk("ff_fault", fetch_fault, 1);
      chk("ff_gnt", fetch_gnt, 0);
      chk("ff_stall", fetch_stall, 0);
      next_cycle();
      fetch_pc = 32'd16380;
      @(negedge clk);
      chk("fb_fault", fetch_fault, 0);
      chk("fb_gnt", fetch_gnt, 1);
      next_cycle();
      fetch_req = 1'b0;
      ld_valid  = 1'b1;
      ld_addr   = 32'd16380;
      ld_data   = 32'hDEADBEEF;
      @(negedge clk);
      chk("lb_rdy", ld_ready, 1);
      next_cycle();
      ld_valid = 1'b0;
      write_cycles("lb", 16380, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0);
      @(negedge clk);
      chk("lb_done", ld_done, 1);
      chk("lb_err", ld_err, 0);
      next_cycle();

      // reset in the middle of a write
      ld_valid = 1'b1;
      ld_addr  = 32'd1000;
      ld_data  = 32'h11223344;
      @(negedge clk);
      chk("rm_rdy", ld_ready, 1);
      next_cycle();
      ld_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("rm_wren%0d", i), mem_wr_en, 1);
         next_cycle();
      end
      rst_n     = 1'b0;
      fetch_req = 1'b1;
      fetch_pc  = 32'd300;
      #1;
      chk("rm_wren_rst", mem_wr_en, 0);
      chk("rm_busy_rst", busy, 0);
      chk("rm_gnt_rst", fetch_gnt, 0);
      chk("rm_stall_rst", fetch_stall, 0);
      chk("rm_done_rst", ld_done, 0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rm_idle_gnt", fetch_gnt, 1);
      chk("rm_idle_wren", mem_wr_en, 0);
      chk("rm_nodone0", ld_done, 0);
      next_cycle();
      @(negedge clk);
      chk("rm_nodone1", ld_done, 0);
      next_cycle();
      chk("rm_b0", mem[1000], 8'h11);
      chk("rm_b1", mem[1001], 8'h22);
      chk("rm_b2", mem[1002], 8'h00);
      chk("rm_b3", mem[1003], 8'h00);

      // back-to-back loads with ld_valid held
      fetch_req = 1'b0;
      ld_valid  = 1'b1;
      ld_addr   = 32'd800;
      ld_data   = 32'h01020304;
      w0 = wr_cnt;
      d0 = done_cnt;
      @(negedge clk);
      chk("bb_rdy0", ld_ready, 1);
      next_cycle();
      ld_addr = 32'd804;
      ld_data = 32'h05060708;
      write_cycles("bb1", 800, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
      @(negedge clk);
      chk("bb_rdy5", ld_ready, 1);
      chk("bb_done1", ld_done, 1);
      next_cycle();
      ld_valid = 1'b0;
      write_cycles("bb2", 804, 8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
      @(negedge clk);
      chk("bb_done2", ld_done, 1);
      next_cycle();
      chk("bb_writes", wr_cnt - w0, 8);
      chk("bb_dones", done_cnt - d0, 2);
      chk("bb_word804", rd_word(32'd804), 32'h05060708);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Sequences and shares the byte-wide instruction memory between two requesters.
- Requester 1 is the IF-stage fetch, which reads one big-endian 32-bit word per cycle.
- Requester 2 is the program loader (testbench/debug), which writes 32-bit words into memory one byte per cycle.
- The block sits between the IF stage, the loader port and the instruction memory. It arbitrates, stalls fetch during loads and rejects illegal accesses.

Parameters:
- DEPTH, 16384: instruction memory size in bytes; legal byte addresses are 0..DEPTH-1.
- STARVE_LIMIT, 8: consecutive cycles a pending load may be denied before it gets forced priority.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  IF stage wants an instruction this cycle.
- fetch_pc  in  32  byte address of the instruction.
- fetch_gnt  out  1  fetch served this cycle; instruction word from memory is valid.
- fetch_stall  out  1  fetch_req & ~fetch_gnt; IF must hold PC.
- fetch_fault  out  1  fetch_req with fetch_pc[1:0]!=0 or fetch_pc>DEPTH-4.
- ld_valid  in  1  loader offers a word.
- ld_addr  in  32  word byte address (big-endian: MSB at ld_addr).
- ld_data  in  32  word to write.
- ld_ready  out  1  loader word accepted this cycle.
- ld_done  out  1  one-cycle pulse when the final byte has been written.
- ld_err  out  1  one-cycle pulse when an accepted word is rejected (misaligned or out of range); nothing is written.
- mem_rd_addr  out  32  read address to memory; equals fetch_pc.
- mem_wr_en  out  1  byte write strobe.
- mem_wr_addr  out  14  byte write address (log2 DEPTH bits).
- mem_wr_data  out  8  byte write data.
- busy  out  1  high while in WRITE state.

Behaviour:
- Reset values (async, rst_n low): state=IDLE, byte_cnt=0, starve_cnt=0, captured addr/data=0. All outputs are 0 except mem_rd_addr, which follows fetch_pc combinationally.
- States: IDLE, WRITE. byte_cnt is 2 bits.
- IDLE arbitration (combinational, same cycle):
  - load_win = ld_valid & (~fetch_req | starve_cnt==STARVE_LIMIT).
  - ld_ready = load_win.
  - fetch_gnt = fetch_req & ~load_win & ~fetch_fault.
- Faulted fetch: never granted and never stalls forever. fetch_stall=0 when fetch_fault=1; IF handles the fault.
- starve_cnt:
  - Increments each IDLE cycle in which ld_valid=1 and load_win=0.
  - Saturates at STARVE_LIMIT.
  - Clears on ld_ready or when ld_valid=0.
- On ld_valid & ld_ready:
  - Illegal address (ld_addr[1:0]!=0 or ld_addr>DEPTH-4): ld_err pulses next cycle and state stays IDLE.
  - Otherwise capture addr/data, byte_cnt<=0, go to WRITE.
- WRITE (exactly 4 cycles, not preemptible):
  - mem_wr_en=1.
  - mem_wr_addr = addr+byte_cnt.
  - mem_wr_data = data[31-8*byte_cnt -: 8] (byte0=[31:24] ... byte3=[7:0]).
  - byte_cnt increments each cycle.
  - On byte_cnt==3: ld_done pulses next cycle, return to IDLE, starve_cnt=0.
- During WRITE: fetch_gnt=0, fetch_stall=fetch_req & ~fetch_fault, ld_ready=0, busy=1.
- Latency: a legal load accepted in cycle T writes bytes in T+1..T+4; ld_done is high in T+5. A back-to-back load can be accepted in T+5.
- Fetch latency is 0 cycles: the read is combinational through the memory.
- Reset mid-WRITE: the write aborts immediately; partially written bytes remain; no ld_done.
- A simultaneous fetch and starved load gives the load priority for one word only.

Decomposition:
- Shared package imem_pkg holds:
  - DEPTH and the derived address width.
  - State encodings IDLE=1'b0, WRITE=1'b1.
  - Function addr_legal(addr) (aligned and within DEPTH-4).
- Sub-module imem_starve_counter: saturating counter with clear and at_limit output. It is the only natural split; the FSM and datapath stay in the top.

Test Plan:
- Fetch only: fetch_req=1, PC=100,104,108 with no load -> fetch_gnt=1 every cycle, stall=0, mem_rd_addr tracks PC, mem_wr_en never set.
- Single load in idle: ld_addr=700, ld_data=0x48080000, fetch_req=0:
  - writes (700,0x48),(701,0x08),(702,0x00),(703,0x00) on consecutive cycles.
  - ld_done pulses once.
  - a fetch at 700 afterwards returns 0x48080000.
- Load during fetch: fetch_req held at 1, ld_valid=1 -> load denied for 8 cycles, accepted in cycle 9, fetch_stall=1 for 4 WRITE cycles, then fetch resumes.
- Illegal loads:
  - ld_addr=702 -> ld_err pulse, no mem_wr_en.
  - ld_addr=16381 -> ld_err pulse, no mem_wr_en.
  - fetch_pc=16382 -> fetch_fault=1, fetch_gnt=0, fetch_stall=0.
- Reset mid-write: assert rst_n=0 after the second byte -> outputs go to 0 immediately, state=IDLE, only bytes 0-1 written, no ld_done.
- Back-to-back loads to 800 and 804 with ld_valid held -> second ld_ready exactly 5 cycles after the first, 8 writes total, two ld_done pulses.
